// File: rtl/conversor_bcd.sv
// ============================================================================
// Module  : conversor_bcd
// Brief   : 8-bit binary to 3-digit BCD converter (sequential double-dabble),
//           optional 7-segment outputs when SEG7_OUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module conversor_bcd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] P,
  output logic       busy,
  output logic       done,
  output logic [3:0] centenas,
  output logic [3:0] dezenas,
  output logic [3:0] unidades
`ifdef SEG7_OUT_EN
  ,
  output logic [6:0] seg_c,
  output logic [6:0] seg_d,
  output logic [6:0] seg_u
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  cent_q, cent_d;
  logic [3:0]  dez_q, dez_d;
  logic [3:0]  uni_q, uni_d;
  logic        done_q, done_d;

  logic [11:0] w_adj;
  logic [11:0] w_shifted;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign w_adj     = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
  assign w_shifted = {w_adj[10:0], shreg_q[7]};

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    cent_d    = cent_q;
    dez_d     = dez_q;
    uni_d     = uni_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          shreg_d   = P;
          scratch_d = 12'd0;
          cnt_d     = 3'd0;
        end
      end
      S_SHIFT: begin
        scratch_d = w_shifted;
        shreg_d   = {shreg_q[6:0], 1'b0};
        cnt_d     = cnt_q + 3'd1;
        // Digits load with the final shift so they are valid while done is high.
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cent_d  = w_shifted[11:8];
          dez_d   = w_shifted[7:4];
          uni_d   = w_shifted[3:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= 8'd0;
      scratch_q <= 12'd0;
      cnt_q     <= 3'd0;
      cent_q    <= 4'd0;
      dez_q     <= 4'd0;
      uni_q     <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      cent_q    <= cent_d;
      dez_q     <= dez_d;
      uni_q     <= uni_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign centenas = cent_q;
  assign dezenas  = dez_q;
  assign unidades = uni_q;

`ifdef SEG7_OUT_EN
  localparam logic [6:0] c_seg_blank = 7'h7F;

  // Active-low, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return c_seg_blank;
    endcase
  endfunction

  assign seg_c = seg7(cent_q);
  assign seg_d = seg7(dez_q);
  assign seg_u = seg7(uni_q);
`endif

endmodule

`default_nettype wire

// File: tb/tb_conversor_bcd.sv
// ============================================================================
// Module  : tb_conversor_bcd
// Brief   : Self-checking bench for conversor_bcd (table vectors + scoreboard);
//           seg checks compiled in when SEG7_OUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conversor_bcd;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] P;
  logic       busy;
  logic       done;
  logic [3:0] centenas;
  logic [3:0] dezenas;
  logic [3:0] unidades;
`ifdef SEG7_OUT_EN
  logic [6:0] seg_c;
  logic [6:0] seg_d;
  logic [6:0] seg_u;
`endif

  conversor_bcd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .P        (P),
    .busy     (busy),
    .done     (done),
    .centenas (centenas),
    .dezenas  (dezenas),
    .unidades (unidades)
`ifdef SEG7_OUT_EN
    ,
    .seg_c    (seg_c),
    .seg_d    (seg_d),
    .seg_u    (seg_u)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  vec_t sb[$];
  vec_t vecs[11];
  logic [6:0] seg_tab[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] p, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] u);
    vec_t v;
    v.p = p; v.c = c; v.d = d; v.u = u;
    return v;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    vec_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("centenas(P=%0d)", e.p), centenas, e.c);
        check($sformatf("dezenas(P=%0d)", e.p), dezenas, e.d);
        check($sformatf("unidades(P=%0d)", e.p), unidades, e.u);
`ifdef SEG7_OUT_EN
        check($sformatf("seg_c(P=%0d)", e.p), seg_c, seg_tab[e.c]);
        check($sformatf("seg_d(P=%0d)", e.p), seg_d, seg_tab[e.d]);
        check($sformatf("seg_u(P=%0d)", e.p), seg_u, seg_tab[e.u]);
`endif
      end
    end
  end

  // Called just after a negedge; returns at the first idle negedge after done.
  task automatic run_conv(input vec_t v, output int lat, output int bcyc);
    P     = v.p;
    start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bcyc  = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (busy) bcyc++;
      if (done && lat == 0) lat = cyc;
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(inout int k);
    while (done !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int lat, bc, k, d0;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[0]  = mk(8'd0,   4'd0, 4'd0, 4'd0);
    vecs[1]  = mk(8'd144, 4'd1, 4'd4, 4'd4);
    vecs[2]  = mk(8'd225, 4'd2, 4'd2, 4'd5);
    vecs[3]  = mk(8'd255, 4'd2, 4'd5, 4'd5);
    vecs[4]  = mk(8'd9,   4'd0, 4'd0, 4'd9);
    vecs[5]  = mk(8'd99,  4'd0, 4'd9, 4'd9);
    vecs[6]  = mk(8'd200, 4'd2, 4'd0, 4'd0);
    vecs[7]  = mk(8'd1,   4'd0, 4'd0, 4'd1);
    vecs[8]  = mk(8'd10,  4'd0, 4'd1, 4'd0);
    vecs[9]  = mk(8'd100, 4'd1, 4'd0, 4'd0);
    vecs[10] = mk(8'd59,  4'd0, 4'd5, 4'd9);

    rst_n = 1'b0;
    start = 1'b0;
    P     = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_digits", {centenas, dezenas, unidades}, 0);
`ifdef SEG7_OUT_EN
    check("reset_segs", {seg_c, seg_d, seg_u}, {7'h40, 7'h40, 7'h40});
`endif

    // First vector (P=0) starts at the first rising edge after release.
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_conv(vecs[i], lat, bc);
      check($sformatf("latency(P=%0d)", vecs[i].p), lat, 9);
      check($sformatf("busy_cycles(P=%0d)", vecs[i].p), bc, 9);
    end

    // Back-to-back: second start in the cycle right after done.
    P = 8'd255; start = 1'b1; sb.push_back(mk(8'd255, 4'd2, 4'd5, 4'd5));
    @(negedge clk);
    start = 1'b0;
    k = 0;
    wait_done(k);
    check("b2b_first_done", done, 1);
    @(negedge clk);
    P = 8'd9; start = 1'b1; sb.push_back(mk(8'd9, 4'd0, 4'd0, 4'd9));
    k = 1;
    @(negedge clk);
    start = 1'b0;
    k = 2;
    wait_done(k);
    check("b2b_done_spacing", k, 10);
    @(negedge clk);

    // Start held high and P toggled while busy, including during done.
    d0 = n_done;
    P = 8'd99; start = 1'b1; sb.push_back(mk(8'd99, 4'd0, 4'd9, 4'd9));
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      P = 8'd200;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    P = 8'd0;
    repeat (20) @(negedge clk);
    check("ignored_start_done_count", n_done - d0, 1);
    check("ignored_start_idle", busy, 0);

    // Asynchronous reset mid-conversion, between clock edges.
    P = 8'd200; start = 1'b1; sb.push_back(mk(8'd200, 4'd2, 4'd0, 4'd0));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_digits", {centenas, dezenas, unidades}, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done;
    repeat (20) @(negedge clk);
    check("midreset_no_done", n_done - d0, 0);
    run_conv(mk(8'd200, 4'd2, 4'd0, 4'd0), lat, bc);
    check("after_reset_latency", lat, 9);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
